// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The WB_ARB_RR_EN macro (see wb_rr_arbiter) selects round-robin over fixed priority.
package regfile_ctrl_pkg;

  localparam int REQ_LOAD   = 0;
  localparam int REQ_LUI    = 1;
  localparam int REQ_JUMP   = 2;
  localparam int NREQ       = 3;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [NREQ-1:0] req_vec_t;

  typedef enum logic [1:0] {
    SRC_LOAD = 2'd0,
    SRC_LUI  = 2'd1,
    SRC_JUMP = 2'd2
  } req_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, issue and register-file write bundle for regfile_wb_arbiter.
interface regfile_wb_arbiter_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   iss_valid;
  logic [ADDR_W-1:0]      iss_rd;
  logic                   iss_ready;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [2**ADDR_W-1:0]   busy_vec;

  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_rd,
    input  req_ready, iss_ready, rf_we, rf_waddr, rf_wdata, busy_vec
  );

  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_rd,
    output req_ready, iss_ready, rf_we, rf_waddr, rf_wdata, busy_vec
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Writeback grant logic: round-robin with WB_ARB_RR_EN defined, else fixed load > lui > jump.
// Grant is combinational and forced to zero while rst is high.
module wb_rr_arbiter
  import regfile_ctrl_pkg::*;
(
`ifdef WB_ARB_RR_EN
  input  logic     clk,
`endif
  input  logic     rst,
  input  req_vec_t req_valid,
  output req_vec_t grant
);

`ifdef WB_ARB_RR_EN
  req_src_e ptr, ptr_nxt;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    if (!rst) begin
      case (ptr)
        SRC_LOAD: begin
          if      (req_valid[0]) grant = 3'b001;
          else if (req_valid[1]) grant = 3'b010;
          else if (req_valid[2]) grant = 3'b100;
        end
        SRC_LUI: begin
          if      (req_valid[1]) grant = 3'b010;
          else if (req_valid[2]) grant = 3'b100;
          else if (req_valid[0]) grant = 3'b001;
        end
        default: begin
          if      (req_valid[2]) grant = 3'b100;
          else if (req_valid[0]) grant = 3'b001;
          else if (req_valid[1]) grant = 3'b010;
        end
      endcase
      // Pointer moves just past the winner so it gets lowest priority next time.
      if      (grant[REQ_LOAD]) ptr_nxt = SRC_LUI;
      else if (grant[REQ_LUI])  ptr_nxt = SRC_JUMP;
      else if (grant[REQ_JUMP]) ptr_nxt = SRC_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= SRC_LOAD;
    else     ptr <= ptr_nxt;
  end
`else
  always_comb begin
    grant = '0;
    if (!rst) begin
      if      (req_valid[REQ_LOAD]) grant[REQ_LOAD] = 1'b1;
      else if (req_valid[REQ_LUI])  grant[REQ_LUI]  = 1'b1;
      else if (req_valid[REQ_JUMP]) grant[REQ_JUMP] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard and registered write port.
// Arbitration mode set by WB_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic             clk,
  input logic             rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int NREG = 2**ADDR_W;

  req_vec_t          grant;
  logic              xfer;
  logic              iss_fire;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_q, busy_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  wb_rr_arbiter u_arb (
`ifdef WB_ARB_RR_EN
    .clk       (clk),
`endif
    .rst       (rst),
    .req_valid (bus.req_valid),
    .grant     (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer          = |grant;
  assign bus.req_ready = grant;
  assign bus.iss_ready = !rst && ((bus.iss_rd == '0) || !busy_q[bus.iss_rd]);
  assign iss_fire      = bus.iss_valid && bus.iss_ready;

  // Clear before set so a same-cycle issue to the written register stays busy.
  always_comb begin
    busy_nxt = busy_q;
    if (xfer)     busy_nxt[sel_addr]   = 1'b0;
    if (iss_fire) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      we_q   <= xfer && (sel_addr != '0);
      if (xfer && (sel_addr != '0)) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model; follows WB_ARB_RR_EN to choose the arbitration rule.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]        = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // Winner by the arbitration rule: scan from ptr upward modulo 3.
  function automatic int model_winner(input bit [2:0] v, input int ptr);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (ptr + k) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 3'b000) $display("FAIL reset_req_ready got %b exp 000", bus.req_ready); else n_pass++;
      n_checks++; if (bus.iss_ready !== 1'b0) $display("FAIL reset_iss_ready got %b exp 0", bus.iss_ready); else n_pass++;
      tick();
    end
    n_checks++; if (bus.rf_we !== 1'b0) $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); else n_pass++;
    n_checks++; if (bus.busy_vec !== 32'h0) $display("FAIL reset_busy got %h exp 0", bus.busy_vec); else n_pass++;
    n_checks++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0)
      $display("FAIL reset_wport got %h/%h exp 0/0", bus.rf_waddr, bus.rf_wdata); else n_pass++;
    clear_inputs();
    rst = 1'b0;
  endtask

`ifdef WB_ARB_RR_EN
  task automatic test_contention();
    logic [2:0]  exp_rdy [3] = '{3'b001, 3'b010, 3'b100};
    logic [4:0]  exp_a   [3] = '{5'd5, 5'd6, 5'd7};
    logic [31:0] exp_d   [3] = '{32'hA, 32'hB, 32'hC};
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, exp_a[i], exp_d[i]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.req_ready !== exp_rdy[k]) $display("FAIL rr_grant%0d got %b exp %b", k, bus.req_ready, exp_rdy[k]); else n_pass++;
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_a[k] || bus.rf_wdata !== exp_d[k])
        $display("FAIL rr_write%0d got %b/%0d/%h exp 1/%0d/%h", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_a[k], exp_d[k]);
      else n_pass++;
      bus.req_valid[k] = 1'b0;
    end
    tick();
    n_checks++; if (bus.rf_we !== 1'b0) $display("FAIL rr_idle_we got %b exp 0", bus.rf_we); else n_pass++;
    clear_inputs();
  endtask
`else
  task automatic test_contention();
    do_reset();
    set_req(2, 1'b1, 5'd4, 32'h4444);
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 5'd3, DW'(k + 1));
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 3'b001) $display("FAIL fp_load_wins%0d got %b exp 001", k, bus.req_ready); else n_pass++;
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== DW'(k + 1))
        $display("FAIL fp_load_write%0d got %b/%0d/%h exp 1/3/%h", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, k + 1);
      else n_pass++;
    end
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 3'b100) $display("FAIL fp_jump_grant got %b exp 100", bus.req_ready); else n_pass++;
    tick();
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h4444)
      $display("FAIL fp_jump_write got %b/%0d/%h exp 1/4/4444", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else n_pass++;
    clear_inputs();
  endtask
`endif

  task automatic test_scoreboard();
    do_reset();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    @(negedge clk);
    n_checks++; if (bus.iss_ready !== 1'b1) $display("FAIL sb_first_issue got %b exp 1", bus.iss_ready); else n_pass++;
    tick();
    n_checks++; if (bus.busy_vec[9] !== 1'b1) $display("FAIL sb_busy_set got %b exp 1", bus.busy_vec[9]); else n_pass++;
    set_req(0, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    n_checks++; if (bus.iss_ready !== 1'b0) $display("FAIL sb_repeat_issue got %b exp 0", bus.iss_ready); else n_pass++;
    n_checks++; if (bus.req_ready !== 3'b001) $display("FAIL sb_wb_grant got %b exp 001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.busy_vec[9] !== 1'b0) $display("FAIL sb_busy_clear got %b exp 0", bus.busy_vec[9]); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.iss_ready !== 1'b1) $display("FAIL sb_reissue got %b exp 1", bus.iss_ready); else n_pass++;
    tick();
    n_checks++; if (bus.busy_vec[9] !== 1'b1) $display("FAIL sb_busy_reset got %b exp 1", bus.busy_vec[9]); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 3'b010) $display("FAIL r0_grant got %b exp 010", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.rf_we !== 1'b0) $display("FAIL r0_no_write got %b exp 0", bus.rf_we); else n_pass++;
    n_checks++; if (bus.rf_wdata !== 32'h0) $display("FAIL r0_wdata_hold got %h exp 0", bus.rf_wdata); else n_pass++;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    @(negedge clk);
    n_checks++; if (bus.iss_ready !== 1'b1) $display("FAIL r0_issue got %b exp 1", bus.iss_ready); else n_pass++;
    tick();
    n_checks++; if (bus.busy_vec !== 32'h0) $display("FAIL r0_busy got %h exp 0", bus.busy_vec); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_set_clear();
    do_reset();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd12;
    set_req(2, 1'b1, 5'd12, 32'h1234);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 3'b100 || bus.iss_ready !== 1'b1)
      $display("FAIL sc_handshakes got %b/%b exp 100/1", bus.req_ready, bus.iss_ready); else n_pass++;
    tick();
    n_checks++; if (bus.busy_vec[12] !== 1'b1) $display("FAIL sc_busy got %b exp 1", bus.busy_vec[12]); else n_pass++;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'h1234)
      $display("FAIL sc_write got %b/%0d/%h exp 1/12/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    bit [2:0]    pend;
    logic [4:0]  paddr [3];
    logic [31:0] pdata [3];
    int          wait_cnt [3];
    int          mptr;
    bit [31:0]   mbusy;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          win;
    bit          exp_iss;
    logic [2:0]  exp_rdy;

    do_reset();
    pend = '0;
    mptr = 0; mbusy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    for (int i = 0; i < 3; i++) begin wait_cnt[i] = 0; paddr[i] = '0; pdata[i] = '0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
          pdata[i] = $urandom;
        end
        set_req(i, pend[i], paddr[i], pdata[i]);
      end
      bus.iss_valid = 1'($urandom % 2);
      bus.iss_rd    = 5'($urandom_range(0, 9));
      rst           = ($urandom % 40 == 0);

      win     = rst ? -1 : model_winner(pend, mptr);
      exp_rdy = (win < 0) ? 3'b000 : 3'(1 << win);
      exp_iss = !rst && ((bus.iss_rd == 0) || !mbusy[bus.iss_rd]);

      @(negedge clk);
      n_checks++; if (bus.req_ready !== exp_rdy) $display("FAIL rnd_ready c%0d got %b exp %b", cyc, bus.req_ready, exp_rdy); else n_pass++;
      n_checks++; if (bus.iss_ready !== exp_iss) $display("FAIL rnd_iss_ready c%0d got %b exp %b", cyc, bus.iss_ready, exp_iss); else n_pass++;

`ifdef WB_ARB_RR_EN
      for (int i = 0; i < 3; i++) begin
        if (rst) wait_cnt[i] = 0;
        else if (pend[i]) begin
          if (win == i) begin
            n_checks++; if (wait_cnt[i] + 1 > 3) $display("FAIL rnd_fair c%0d req%0d waited %0d exp <=3", cyc, i, wait_cnt[i] + 1); else n_pass++;
            wait_cnt[i] = 0;
          end else wait_cnt[i]++;
        end
      end
`endif

      tick();
      if (rst) begin
        mbusy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; mptr = 0;
      end else begin
        m_we = 1'b0;
        if (win >= 0) begin
          mbusy[paddr[win]] = 1'b0;
          if (paddr[win] != 0) begin
            m_we = 1'b1; m_waddr = paddr[win]; m_wdata = pdata[win];
          end
`ifdef WB_ARB_RR_EN
          mptr = (win + 1) % 3;
`endif
          pend[win] = 1'b0;
        end
        if (exp_iss && bus.iss_valid && bus.iss_rd != 0) mbusy[bus.iss_rd] = 1'b1;
      end

      n_checks++; if (bus.rf_we !== m_we) $display("FAIL rnd_we c%0d got %b exp %b", cyc, bus.rf_we, m_we); else n_pass++;
      n_checks++; if (bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata)
        $display("FAIL rnd_wport c%0d got %0d/%h exp %0d/%h", cyc, bus.rf_waddr, bus.rf_wdata, m_waddr, m_wdata); else n_pass++;
      n_checks++; if (bus.busy_vec !== mbusy) $display("FAIL rnd_busy c%0d got %h exp %h", cyc, bus.busy_vec, mbusy); else n_pass++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_contention();
    test_scoreboard();
    test_reg_zero();
    test_set_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
